// File: rtl/obi_mem_responder.sv
// OBI target backed by a word-addressed RAM, with programmable grant wait-states and
// a fixed-latency, in-order response pipeline.
//
// state   | meaning
// ST_IDLE | no request being delayed; a new request starts the wait-state count
// ST_WAIT | counting down wait-states; grant when the counter reaches zero
module obi_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned GNT_DELAY = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           obi_req_i,
  output logic                           obi_gnt_o,
  input  logic [31:0]                    obi_addr_i,
  input  logic                           obi_we_i,
  input  logic [3:0]                     obi_be_i,
  input  logic [31:0]                    obi_wdata_i,
  output logic                           obi_rvalid_o,
  output logic [31:0]                    obi_rdata_o,
  output logic                           obi_err_o,
  output logic [$clog2(LATENCY+1)-1:0]   outstanding_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(LATENCY + 1);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t          state, state_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic            gnt;
  logic            accept;
  logic [32:0]     addr_ext;
  logic            in_range;
  logic [31:0]     offset;
  logic [AW-1:0]   idx;
  logic            unused_offset;
  logic [31:0]     rd_word;
  logic [OW-1:0]   outstanding;

  logic [31:0]        mem [DEPTH];
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_err;
  logic [31:0]        pipe_data [LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Grant is held low while in reset, so a request in the reset cycle is never accepted.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt       = 1'b0;
    if (rst_i) begin
      state_nxt = ST_IDLE;
    end else if (GNT_DELAY == 0) begin
      gnt       = obi_req_i;
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (obi_req_i) begin
            cnt_nxt   = 8'(GNT_DELAY - 1);
            state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          gnt = obi_req_i && (cnt == 8'd0);
          if (!obi_req_i || cnt == 8'd0) state_nxt = ST_IDLE;
          else cnt_nxt = cnt - 8'd1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign accept = obi_req_i & gnt;

  assign addr_ext      = {1'b0, obi_addr_i};
  assign in_range      = (addr_ext >= {1'b0, BASE_ADDR}) && (addr_ext < LIMIT);
  assign offset        = obi_addr_i - BASE_ADDR;
  assign idx           = offset[AW+1:2];
  assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

  always_ff @(posedge clk_i) begin
    if (accept && obi_we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (obi_be_i[k]) mem[idx][8*k +: 8] <= obi_wdata_i[8*k +: 8];
      end
    end
  end

  assign rd_word = (accept && !obi_we_i && in_range) ? mem[idx] : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept & ~in_range;
      pipe_data[0]  <= rd_word;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) outstanding <= '0;
    else outstanding <= outstanding + OW'(accept) - OW'(pipe_valid[LATENCY-1]);
  end

  assign obi_gnt_o     = gnt;
  assign obi_rvalid_o  = pipe_valid[LATENCY-1] & ~rst_i;
  assign obi_err_o     = pipe_err[LATENCY-1] & ~rst_i;
  assign obi_rdata_o   = rst_i ? 32'd0 : pipe_data[LATENCY-1];
  assign outstanding_o = rst_i ? '0 : outstanding;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: a zero-wait instance and a 3-wait-state instance, both
// checked cycle by cycle against a transaction-level model (RAM array + response queue).
module tb_obi_mem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          LAT   = 2;
  localparam int          LAT_D = 3;
  localparam int          GNT_D = 3;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req, we, gnt, rvalid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic [1:0]  outstanding;

  logic        req_d, we_d, gnt_d, rvalid_d, err_d;
  logic [31:0] addr_d, wdata_d, rdata_d;
  logic [3:0]  be_d;
  logic [1:0]  outstanding_d;

  obi_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT), .GNT_DELAY(0)) dut (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid),
    .obi_rdata_o(rdata), .obi_err_o(err), .outstanding_o(outstanding)
  );

  obi_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT_D), .GNT_DELAY(GNT_D)) dut_d (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req_d), .obi_gnt_o(gnt_d), .obi_addr_i(addr_d),
    .obi_we_i(we_d), .obi_be_i(be_d), .obi_wdata_i(wdata_d), .obi_rvalid_o(rvalid_d),
    .obi_rdata_o(rdata_d), .obi_err_o(err_d), .outstanding_o(outstanding_d)
  );

  rsp_t        q[$];
  rsp_t        qd[$];
  logic [31:0] mem_m  [DEPTH];
  logic [31:0] mem_md [DEPTH];
  int          cyc, age_d, total, bad;

  logic        exp_gnt, exp_rvalid, exp_err;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_out;
  logic        exp_gnt_d, exp_rvalid_d, exp_err_d;
  logic [31:0] exp_rdata_d;
  logic [1:0]  exp_out_d;

  // Transaction-level effect of one accepted access on the model RAM and response queue.
  task automatic model_access(input logic [31:0] a, input logic w, input logic [3:0] b,
                              input logic [31:0] d, input int due, input bit is_d);
    longint ai;
    bit     inr;
    int     ix;
    rsp_t   r;
    ai     = a;
    inr    = (ai >= longint'(BASE)) && (ai < longint'(BASE) + 4 * DEPTH);
    r.due  = due;
    r.err  = !inr;
    r.data = 32'd0;
    if (inr) begin
      ix = int'((ai - longint'(BASE)) / 4);
      for (int k = 0; k < 4; k++) begin
        if (!w) begin
          r.data = is_d ? mem_md[ix] : mem_m[ix];
        end else if (b[k]) begin
          if (is_d) mem_md[ix][8*k +: 8] = d[8*k +: 8];
          else      mem_m[ix][8*k +: 8]  = d[8*k +: 8];
        end
      end
    end
    if (is_d) qd.push_back(r);
    else      q.push_back(r);
  endtask

  task automatic predict();
    @(negedge clk);
    exp_gnt = 0; exp_rvalid = 0; exp_err = 0; exp_rdata = 0; exp_out = 0;
    exp_gnt_d = 0; exp_rvalid_d = 0; exp_err_d = 0; exp_rdata_d = 0; exp_out_d = 0;
    if (!rst) begin
      exp_gnt    = req;
      exp_out    = 2'(q.size());
      exp_rvalid = (q.size() > 0) && (q[0].due == cyc);
      if (exp_rvalid) begin
        exp_err   = q[0].err;
        exp_rdata = q[0].data;
      end
      exp_gnt_d    = req_d && (age_d == GNT_D);
      exp_out_d    = 2'(qd.size());
      exp_rvalid_d = (qd.size() > 0) && (qd[0].due == cyc);
      if (exp_rvalid_d) begin
        exp_err_d   = qd[0].err;
        exp_rdata_d = qd[0].data;
      end
    end
  endtask

  task automatic commit();
    if (rst) begin
      q.delete();
      qd.delete();
      age_d = 0;
    end else begin
      if (exp_rvalid) void'(q.pop_front());
      if (exp_rvalid_d) void'(qd.pop_front());
      if (req && exp_gnt) model_access(addr, we, be, wdata, cyc + LAT, 1'b0);
      if (req_d && exp_gnt_d) begin
        model_access(addr_d, we_d, be_d, wdata_d, cyc + LAT_D, 1'b1);
        age_d = 0;
      end else if (req_d) age_d++;
      else age_d = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input stim_t s);
    req = s.r; we = s.w; addr = s.a; be = s.b; wdata = s.d;
  endtask

  task automatic test_reset();
    rst = 1; req = 1; we = 0; addr = BASE; req_d = 1;
    for (int i = 0; i < 2; i++) begin
      predict();
      total += 5;
      if (gnt !== 1'b0)         begin bad++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
      if (rvalid !== 1'b0)      begin bad++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
      if (err !== 1'b0)         begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      if (outstanding !== 2'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
      if (gnt_d !== 1'b0)       begin bad++; $display("FAIL reset_gnt_d got=%b exp=0", gnt_d); end
      commit();
    end
    rst = 0; req = 0; req_d = 0;
  endtask

  task automatic test_write_read();
    stim_t s;
    int    rd_cyc;
    rd_cyc = -100;
    for (int i = 0; i < DEPTH + 6; i++) begin
      s = '{0, 0, BASE, 4'h0, 32'd0};
      if (i < DEPTH)       s = '{1, 1, BASE + 32'(4 * i), 4'hF, $urandom};
      else if (i == DEPTH) s = '{1, 1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF};
      else if (i == DEPTH + 1) begin
        s = '{1, 0, BASE + 32'h10, 4'h0, 32'd0};
        rd_cyc = cyc;
      end
      apply(s);
      predict();
      total += 3;
      if (gnt !== exp_gnt)       begin bad++; $display("FAIL wr_rd_gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt); end
      if (rvalid !== exp_rvalid) begin bad++; $display("FAIL wr_rd_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, exp_rvalid); end
      if (outstanding !== exp_out) begin bad++; $display("FAIL wr_rd_outstanding cyc=%0d got=%0d exp=%0d", cyc, outstanding, exp_out); end
      if (exp_rvalid) begin
        total++;
        if (rdata !== exp_rdata || err !== exp_err) begin
          bad++; $display("FAIL wr_rd_data cyc=%0d got=%h/%b exp=%h/%b", cyc, rdata, err, exp_rdata, exp_err);
        end
      end
      if (cyc == rd_cyc + LAT) begin
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
          bad++; $display("FAIL deadbeef_read got=%b/%h exp=1/deadbeef", rvalid, rdata);
        end
      end
      commit();
    end
  endtask

  task automatic test_byte_enable();
    stim_t s;
    int    rd_cyc;
    rd_cyc = -100;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: s = '{1, 1, BASE + 32'h20, 4'b1111, 32'h1122_3344};
        1: s = '{1, 1, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD};
        2: begin s = '{1, 0, BASE + 32'h20, 4'b0000, 32'd0}; rd_cyc = cyc; end
        default: s = '{0, 0, BASE, 4'h0, 32'd0};
      endcase
      apply(s);
      predict();
      total += 2;
      if (rvalid !== exp_rvalid) begin bad++; $display("FAIL be_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, exp_rvalid); end
      if (outstanding !== exp_out) begin bad++; $display("FAIL be_outstanding cyc=%0d got=%0d exp=%0d", cyc, outstanding, exp_out); end
      if (cyc == rd_cyc + LAT) begin
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'h11BB_33DD) begin
          bad++; $display("FAIL be_merge got=%b/%h exp=1/11bb33dd", rvalid, rdata);
        end
      end
      commit();
    end
  endtask

  task automatic test_out_of_range();
    stim_t s;
    int    c_hi, c_lo;
    c_hi = -100; c_lo = -100;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin s = '{1, 0, BASE + 32'(4 * DEPTH), 4'h0, 32'd0}; c_hi = cyc; end
        1: begin s = '{1, 0, BASE - 32'd4, 4'h0, 32'd0}; c_lo = cyc; end
        2: s = '{1, 1, BASE + 32'(4 * DEPTH), 4'hF, 32'h5555_5555};
        3: s = '{1, 1, BASE - 32'd4, 4'hF, 32'h6666_6666};
        4: s = '{1, 0, BASE, 4'h0, 32'd0};
        5: s = '{1, 0, BASE + 32'(4 * DEPTH - 4), 4'h0, 32'd0};
        6: s = '{1, 0, 32'hFFFF_FFFC, 4'h0, 32'd0};
        default: s = '{0, 0, BASE, 4'h0, 32'd0};
      endcase
      apply(s);
      predict();
      total++;
      if (rvalid !== exp_rvalid) begin bad++; $display("FAIL oor_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, exp_rvalid); end
      if (exp_rvalid) begin
        total++;
        if (rdata !== exp_rdata || err !== exp_err) begin
          bad++; $display("FAIL oor_data cyc=%0d got=%h/%b exp=%h/%b", cyc, rdata, err, exp_rdata, exp_err);
        end
      end
      if (cyc == c_hi + LAT || cyc == c_lo + LAT) begin
        total++;
        if (err !== 1'b1 || rdata !== 32'd0) begin
          bad++; $display("FAIL oor_err cyc=%0d got=%b/%h exp=1/00000000", cyc, err, rdata);
        end
      end
      commit();
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 250; i++) begin
      s.r = ($urandom_range(0, 99) < 75);
      s.w = ($urandom_range(0, 99) < 40);
      s.b = 4'($urandom_range(0, 15));
      s.d = $urandom;
      case ($urandom_range(0, 19))
        0:       s.a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
        1:       s.a = BASE - 32'd4 - 32'(4 * $urandom_range(0, 15));
        default: s.a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      s.a = s.a | 32'($urandom_range(0, 3));
      if (i >= 245) s.r = 0;
      apply(s);
      predict();
      total += 3;
      if (gnt !== exp_gnt)       begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt); end
      if (rvalid !== exp_rvalid) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, exp_rvalid); end
      if (outstanding !== exp_out) begin bad++; $display("FAIL rnd_outstanding cyc=%0d got=%0d exp=%0d", cyc, outstanding, exp_out); end
      if (exp_rvalid) begin
        total++;
        if (rdata !== exp_rdata || err !== exp_err) begin
          bad++; $display("FAIL rnd_data cyc=%0d got=%h/%b exp=%h/%b", cyc, rdata, err, exp_rdata, exp_err);
        end
      end
      commit();
    end
  endtask

  task automatic test_stream_reset();
    stim_t       s;
    int          peak, nrsp, rd_cyc;
    logic [31:0] keep;
    peak = 0; nrsp = 0; rd_cyc = -100;
    keep = mem_m[5];
    for (int i = 0; i < 22; i++) begin
      rst = 0;
      s = '{0, 0, BASE, 4'h0, 32'd0};
      if (i < 8) s = '{1, 0, BASE + 32'(4 * i), 4'h0, 32'd0};
      else if (i >= 11 && i < 15) s = '{1, 0, BASE + 32'(4 * (i + 10)), 4'h0, 32'd0};
      else if (i == 15) begin
        rst = 1;
        s = '{1, 1, BASE + 32'd20, 4'hF, 32'h0BAD_F00D};
      end else if (i == 20) begin
        s = '{1, 0, BASE + 32'd20, 4'h0, 32'd0};
        rd_cyc = cyc;
      end
      apply(s);
      predict();
      total += 3;
      if (rvalid !== exp_rvalid) begin bad++; $display("FAIL stream_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, exp_rvalid); end
      if (outstanding !== exp_out) begin bad++; $display("FAIL stream_outstanding cyc=%0d got=%0d exp=%0d", cyc, outstanding, exp_out); end
      if (gnt !== exp_gnt)       begin bad++; $display("FAIL stream_gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt); end
      if (exp_rvalid) begin
        total++;
        if (rdata !== exp_rdata || err !== exp_err) begin
          bad++; $display("FAIL stream_data cyc=%0d got=%h/%b exp=%h/%b", cyc, rdata, err, exp_rdata, exp_err);
        end
      end
      if (i < 11) begin
        if (int'(outstanding) > peak) peak = int'(outstanding);
        if (rvalid === 1'b1) nrsp++;
      end
      if (i >= 15 && i <= 19) begin
        total++;
        if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid cyc=%0d got=%b exp=0", cyc, rvalid); end
      end
      if (cyc == rd_cyc + LAT) begin
        total++;
        if (rvalid !== 1'b1 || rdata !== keep) begin
          bad++; $display("FAIL rst_preserve got=%b/%h exp=1/%h", rvalid, rdata, keep);
        end
      end
      commit();
    end
    rst = 0;
    total += 2;
    if (peak !== 2) begin bad++; $display("FAIL stream_peak got=%0d exp=2", peak); end
    if (nrsp !== 8) begin bad++; $display("FAIL stream_count got=%0d exp=8", nrsp); end
  endtask

  task automatic check_d(input string tag);
    // no comparisons here; kept empty on purpose is not allowed, so unused
  endtask

  task automatic test_gnt_delay();
    int t0, g0, g1, n_acc, t_re, g_re, phase;
    req = 0;
    t0 = cyc; g0 = -1; g1 = -1; n_acc = 0; t_re = -1; g_re = -1; phase = 0;
    req_d = 1; we_d = 1; addr_d = BASE + 32'd8; wdata_d = 32'hCAFE_F00D; be_d = 4'hF;
    for (int i = 0; i < 32; i++) begin
      predict();
      total += 3;
      if (gnt_d !== exp_gnt_d)       begin bad++; $display("FAIL dly_gnt cyc=%0d got=%b exp=%b", cyc, gnt_d, exp_gnt_d); end
      if (rvalid_d !== exp_rvalid_d) begin bad++; $display("FAIL dly_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid_d, exp_rvalid_d); end
      if (outstanding_d !== exp_out_d) begin bad++; $display("FAIL dly_outstanding cyc=%0d got=%0d exp=%0d", cyc, outstanding_d, exp_out_d); end
      if (exp_rvalid_d) begin
        total++;
        if (rdata_d !== exp_rdata_d || err_d !== exp_err_d) begin
          bad++; $display("FAIL dly_data cyc=%0d got=%h/%b exp=%h/%b", cyc, rdata_d, err_d, exp_rdata_d, exp_err_d);
        end
      end
      if (gnt_d === 1'b1) begin
        if (g0 < 0) g0 = cyc;
        else if (g1 < 0) g1 = cyc;
        else if (g_re < 0) g_re = cyc;
      end
      if (g1 >= 0 && cyc == g1 + LAT_D) begin
        total++;
        if (rvalid_d !== 1'b1 || rdata_d !== 32'hCAFE_F00D) begin
          bad++; $display("FAIL dly_readback got=%b/%h exp=1/cafef00d", rvalid_d, rdata_d);
        end
      end
      if (req_d && exp_gnt_d) n_acc++;
      commit();
      // stimulus for the next cycle follows the model's view of accepts
      if (phase == 0) begin
        if (n_acc == 1) we_d = 0;
        if (n_acc == 2) begin req_d = 0; phase = 1; end
      end else if (phase == 1) begin
        req_d = 1; phase = 2;
      end else if (phase == 2) begin
        phase = 3;
      end else if (phase == 3) begin
        req_d = 0; phase = 4;
      end else if (phase == 4) begin
        req_d = 1; t_re = cyc; phase = 5;
      end else if (phase == 5 && n_acc == 3) begin
        req_d = 0; phase = 6;
      end
    end
    req_d = 0;
    total += 3;
    if (g0 - t0 !== GNT_D)     begin bad++; $display("FAIL dly_first_gnt got=%0d exp=%0d", g0 - t0, GNT_D); end
    if (g1 - t0 !== 2*GNT_D+1) begin bad++; $display("FAIL dly_second_gnt got=%0d exp=%0d", g1 - t0, 2*GNT_D+1); end
    if (g_re - t_re !== GNT_D) begin bad++; $display("FAIL dly_after_drop got=%0d exp=%0d", g_re - t_re, GNT_D); end
  endtask

  initial begin
    rst = 1; req = 0; we = 0; addr = BASE; be = 4'h0; wdata = 32'd0;
    req_d = 0; we_d = 0; addr_d = BASE; be_d = 4'hF; wdata_d = 32'd0;
    total = 0; bad = 0; cyc = 0; age_d = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_random();
    test_stream_reset();
    test_gnt_delay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
